// File: rtl/dropout_pkg.sv
// Shared definitions for the dropout backward gate: default sizes, FSM states
// and the saturating left-shift used to rescale kept gradients.
package dropout_pkg;

  localparam int DEF_NEURONS     = 8;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_GW          = 8;
  localparam int DEF_SCALE_SHIFT = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Shift is done in 64 bits so no bits are lost before clamping to a gw-bit range.
  function automatic longint sat_shl(input longint value, input int shift, input int gw);
    longint v;
    longint maxv;
    longint minv;
    v    = value <<< shift;
    maxv = (longint'(1) <<< (gw - 1)) - 1;
    minv = -(longint'(1) <<< (gw - 1));
    if (v > maxv) begin
      v = maxv;
    end else if (v < minv) begin
      v = minv;
    end
    return v;
  endfunction

endpackage

// File: rtl/mask_lifo.sv
// LIFO of dropout masks; a same-cycle push and pop returns the old top and
// writes the new mask into the slot the pop vacates.
module mask_lifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_push_idx;
  logic             w_do_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_top_idx  = AW'(r_count - CW'(1));
  assign w_push_idx = AW'(r_count);
  assign w_do_pop   = i_pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (w_do_pop && i_push) begin
      r_stack[w_top_idx] <= i_din;
    end else if (w_do_pop) begin
      r_count <= r_count - CW'(1);
    end else if (i_push && !w_full) begin
      r_stack[w_push_idx] <= i_din;
      r_count             <= r_count + CW'(1);
    end
  end

  assign o_dout     = r_stack[w_top_idx];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = i_push & ~w_do_pop & w_full;

endmodule

// File: rtl/dropout_backward_gate.sv
// Backward dropout gate: pops forward masks in reverse order and zeroes or
// rescales (saturating shift) each neuron's gradient in a serial stream.
module dropout_backward_gate
  import dropout_pkg::*;
#(
  parameter int NEURONS     = DEF_NEURONS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int GW          = DEF_GW,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int IW          = $clog2(NEURONS),
  parameter int CW          = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ena,
  input  logic                 i_clear,
  input  logic                 i_fwd_mask_valid,
  input  logic [NEURONS-1:0]   i_fwd_mask,
  input  logic                 i_grad_valid,
  input  logic signed [GW-1:0] i_grad_in,
  output logic                 o_grad_ready,
  output logic signed [GW-1:0] o_grad_out,
  output logic                 o_out_valid,
  output logic [IW-1:0]        o_out_idx,
  output logic                 o_out_last,
  output logic [CW-1:0]        o_stack_count,
  output logic                 o_stack_full,
  output logic                 o_stack_empty,
  output logic                 o_err_overflow,
  output logic                 o_err_underflow
);

  state_t                r_state;
  state_t                w_next_state;
  logic [IW-1:0]         r_idx;
  logic [NEURONS-1:0]    r_mask;
  logic signed [GW-1:0]  r_grad_out;
  logic                  r_out_valid;
  logic [IW-1:0]         r_out_idx;
  logic                  r_out_last;
  logic                  r_err_overflow;
  logic                  r_err_underflow;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_underflow;
  logic                  w_last_idx;
  logic [NEURONS-1:0]    w_lifo_dout;
  logic [CW-1:0]         w_lifo_count;
  logic                  w_lifo_full;
  logic                  w_lifo_empty;
  logic                  w_lifo_overflow;
  logic signed [GW-1:0]  w_scaled;

  assign w_push     = i_fwd_mask_valid & i_ena;
  assign w_last_idx = (r_idx == IW'(NEURONS - 1));
  assign w_scaled   = GW'(sat_shl(longint'(i_grad_in), SCALE_SHIFT, GW));

  mask_lifo #(
    .DEPTH (DEPTH),
    .WIDTH (NEURONS)
  ) u_mask_lifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (i_clear),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_din      (i_fwd_mask),
    .o_dout     (w_lifo_dout),
    .o_count    (w_lifo_count),
    .o_full     (w_lifo_full),
    .o_empty    (w_lifo_empty),
    .o_overflow (w_lifo_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (i_clear) begin
      r_state <= IDLE;
    end else if (i_ena) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_lifo_empty) w_next_state = STREAM;
      STREAM:  if (w_accept && w_last_idx) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ready     = 1'b0;
    w_pop       = 1'b0;
    w_underflow = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop       = i_ena & ~i_clear & ~w_lifo_empty;
        w_underflow = i_ena & i_grad_valid & w_lifo_empty;
      end
      STREAM:  w_ready = i_ena;
      default: w_ready = 1'b0;
    endcase
    w_accept = w_ready & i_grad_valid;
  end

  // Pop loads the mask for the next pass; accepted words are gated and registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx           <= '0;
      r_mask          <= '0;
      r_grad_out      <= '0;
      r_out_valid     <= 1'b0;
      r_out_idx       <= '0;
      r_out_last      <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else if (i_clear) begin
      r_idx           <= '0;
      r_mask          <= '0;
      r_grad_out      <= '0;
      r_out_valid     <= 1'b0;
      r_out_idx       <= '0;
      r_out_last      <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else if (!i_ena) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_pop) begin
        r_mask <= w_lifo_dout;
        r_idx  <= '0;
      end
      if (w_accept) begin
        r_grad_out <= r_mask[r_idx] ? w_scaled : '0;
        r_out_idx  <= r_idx;
        r_out_last <= w_last_idx;
        r_idx      <= w_last_idx ? '0 : r_idx + IW'(1);
      end
      if (w_lifo_overflow) r_err_overflow <= 1'b1;
      if (w_underflow) r_err_underflow <= 1'b1;
    end
  end

  assign o_grad_ready    = w_ready;
  assign o_grad_out      = r_grad_out;
  assign o_out_valid     = r_out_valid;
  assign o_out_idx       = r_out_idx;
  assign o_out_last      = r_out_last;
  assign o_stack_count   = w_lifo_count;
  assign o_stack_full    = w_lifo_full;
  assign o_stack_empty   = w_lifo_empty;
  assign o_err_overflow  = r_err_overflow;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_dropout_backward_gate.sv
// Randomized and directed bench for dropout_backward_gate against a queue-based
// reference model of the mask stack and gradient gating.
module tb_dropout_backward_gate;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              clear;
  logic              fwdValid;
  logic [7:0]        fwdMask;
  logic              gradValid;
  logic signed [7:0] gradIn;
  logic              gradReady;
  logic signed [7:0] gradOut;
  logic              outValid;
  logic [2:0]        outIdx;
  logic              outLast;
  logic [3:0]        stackCount;
  logic              stackFull;
  logic              stackEmpty;
  logic              errOverflow;
  logic              errUnderflow;

  int checkCount;
  int failCount;

  // Reference model state
  int q[$];
  bit mStream;
  int mMask;
  int mIdx;
  bit mOv;
  bit mUn;
  bit eValid;
  int eGrad;
  int eIdx;
  bit eLast;

  dropout_backward_gate dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_ena           (ena),
    .i_clear         (clear),
    .i_fwd_mask_valid(fwdValid),
    .i_fwd_mask      (fwdMask),
    .i_grad_valid    (gradValid),
    .i_grad_in       (gradIn),
    .o_grad_ready    (gradReady),
    .o_grad_out      (gradOut),
    .o_out_valid     (outValid),
    .o_out_idx       (outIdx),
    .o_out_last      (outLast),
    .o_stack_count   (stackCount),
    .o_stack_full    (stackFull),
    .o_stack_empty   (stackEmpty),
    .o_err_overflow  (errOverflow),
    .o_err_underflow (errUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int satScale(input int g);
    int v;
    v = g * 2;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic modelReset();
    q.delete();
    mStream = 0;
    mMask   = 0;
    mIdx    = 0;
    mOv     = 0;
    mUn     = 0;
    eValid  = 0;
    eGrad   = 0;
    eIdx    = 0;
    eLast   = 0;
  endtask

  task automatic modelStep(input bit push, input int mask, input bit gv, input int grad,
                           input bit en, input bit clr);
    bit accept;
    bit pop;
    int top;
    if (clr) begin
      modelReset();
    end else if (!en) begin
      eValid = 0;
    end else begin
      accept = mStream && gv;
      pop    = !mStream && (q.size() > 0);
      if (!mStream && q.size() == 0 && gv) mUn = 1;
      eValid = accept;
      if (accept) begin
        eGrad = ((mMask >> mIdx) & 1) ? satScale(grad) : 0;
        eIdx  = mIdx;
        eLast = (mIdx == 7);
        mIdx++;
        if (mIdx == 8) begin
          mStream = 0;
          mIdx    = 0;
        end
      end
      if (pop) begin
        top = q.pop_back();
        if (push) q.push_back(mask);
        mMask   = top;
        mStream = 1;
        mIdx    = 0;
      end else if (push) begin
        if (q.size() == 8) mOv = 1;
        else q.push_back(mask);
      end
    end
  endtask

  task automatic checkRegs();
    checkOutput("out_valid", int'(outValid), int'(eValid));
    if (eValid) begin
      checkOutput("grad_out", int'(gradOut), eGrad);
      checkOutput("out_idx", int'(outIdx), eIdx);
      checkOutput("out_last", int'(outLast), int'(eLast));
    end
    checkOutput("stack_count", int'(stackCount), q.size());
    checkOutput("stack_full", int'(stackFull), int'(q.size() == 8));
    checkOutput("stack_empty", int'(stackEmpty), int'(q.size() == 0));
    checkOutput("err_overflow", int'(errOverflow), int'(mOv));
    checkOutput("err_underflow", int'(errUnderflow), int'(mUn));
  endtask

  // One clock: drive inputs, check ready, clock, update model, check registers.
  task automatic applyStimulus(input bit push, input int mask, input bit gv, input int grad,
                               input bit en, input bit clr);
    fwdValid  = push;
    fwdMask   = 8'(mask);
    gradValid = gv;
    gradIn    = 8'(grad);
    ena       = en;
    clear     = clr;
    #1;
    checkOutput("grad_ready", int'(gradReady), int'(mStream && en));
    @(posedge clk);
    modelStep(push, mask, gv, grad, en, clr);
    #1;
    checkRegs();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1, 0);
  endtask

  task automatic streamPass(input int base);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, base + i, 1, 0);
  endtask

  task automatic pulseClear();
    applyStimulus(0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    int satGrads[4];
    checkCount = 0;
    failCount  = 0;
    satGrads   = '{100, -100, 63, -64};
    rst_n = 1'b0; ena = 1'b0; clear = 1'b0; fwdValid = 1'b0;
    fwdMask = '0; gradValid = 1'b0; gradIn = '0;
    modelReset();
    #2;
    checkOutput("reset_ready", int'(gradReady), 0);
    checkRegs();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two masks, two passes of grads 1..8
    $display("[TB] two-pass gating");
    applyStimulus(1, 8'h0F, 0, 0, 1, 0);
    applyStimulus(1, 8'hA5, 0, 0, 1, 0);
    streamPass(1);
    idleCycles(1);
    streamPass(1);
    idleCycles(2);

    // Saturation with an all-kept mask
    $display("[TB] saturation");
    applyStimulus(1, 8'hFF, 0, 0, 1, 0);
    idleCycles(1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, satGrads[i], 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, -128 + 85 * i, 1, 0);
    idleCycles(1);

    // Overflow while a pass is in progress
    $display("[TB] overflow");
    applyStimulus(1, 8'h55, 0, 0, 1, 0);
    for (int m = 1; m <= 9; m++) applyStimulus(1, m, 0, 0, 1, 0);
    streamPass(10);
    idleCycles(1);
    streamPass(20);
    pulseClear();

    // Underflow on empty stack, then clear
    $display("[TB] underflow");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 5, 1, 0);
    pulseClear();
    idleCycles(1);

    // Same-cycle push and pop on a full stack
    $display("[TB] push with pop on full stack");
    applyStimulus(1, 8'h66, 0, 0, 1, 0);
    for (int m = 1; m <= 8; m++) applyStimulus(1, m * 8'h11 & 8'hFF, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 3 + i, 1, 0);
    applyStimulus(1, 8'h3C, 0, 0, 1, 0);
    streamPass(-4);
    idleCycles(1);
    streamPass(30);
    pulseClear();

    // Async reset in the middle of a pass
    $display("[TB] reset mid-stream");
    applyStimulus(1, 8'hFF, 0, 0, 1, 0);
    applyStimulus(1, 8'h81, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 7 + i, 1, 0);
    fwdValid = 1'b0; gradValid = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_out_valid", int'(outValid), 0);
    checkOutput("rst_count", int'(stackCount), 0);
    checkOutput("rst_ready", int'(gradReady), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(3);

    // Randomized traffic including enable gaps and occasional clears
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
                    $urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128,
                    $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
